// File: rtl/onchip_mem_block_mover.sv
// ============================================================================
// Module      : onchip_mem_block_mover
// Description : Avalon-MM master that drives a single-port on-chip RAM
//               (address/byteenable/chipselect/write/writedata/readdata) and
//               executes one block command at a time:
//                 COPY - move len words from src to dst (ascending, one read
//                        then one write per word)
//                 FILL - write a constant pattern over len words
//               Every output is registered. The bus outputs are computed
//               from the next state, so they line up with the state the FSM
//               is in on each cycle.
// Ports       : clk, reset             - clock, synchronous active-high reset
//               cmd_valid/cmd_ready    - command handshake (ready == idle)
//               cmd_mode/src/dst/len/fill - command fields, latched on accept
//               abort                  - stop the running command early
//               busy/done/aborted      - status; done is a one-cycle pulse and
//                                        aborted is only valid alongside done
//               words_done             - words written by current/last command
//               address/byteenable/chipselect/write/writedata/readdata
//                                      - RAM master interface
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onchip_mem_block_mover #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    // command side
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_mode,
    input  logic [ADDR_W-1:0]   cmd_src,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [ADDR_W:0]     cmd_len,
    input  logic [DATA_W-1:0]   cmd_fill,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [ADDR_W:0]     words_done,
    // memory side
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   readdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WT   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    // WT counts down from READ_LATENCY-1; readdata is captured at zero.
    localparam logic [2:0]        LAT_LAST = 3'(READ_LATENCY - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    // control state
    logic [2:0]          state_q,      state_d;
    logic [ADDR_W-1:0]   src_q,        src_d;
    logic [ADDR_W-1:0]   dst_q,        dst_d;
    logic [ADDR_W:0]     rem_q,        rem_d;
    logic                mode_q,       mode_d;
    logic [DATA_W-1:0]   fill_q,       fill_d;
    logic [DATA_W-1:0]   data_q,       data_d;
    logic [2:0]          lat_q,        lat_d;
    logic                abort_flag_q, abort_flag_d;
    logic [ADDR_W:0]     words_done_q, words_done_d;

    // registered outputs
    logic                ready_q,      ready_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic                aborted_q,    aborted_d;
    logic [ADDR_W-1:0]   address_q,    address_d;
    logic [DATA_W/8-1:0] be_q,         be_d;
    logic                cs_q,         cs_d;
    logic                wr_q,         wr_d;
    logic [DATA_W-1:0]   wdata_q,      wdata_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        mode_d       = mode_q;
        fill_d       = fill_q;
        data_d       = data_q;
        lat_d        = lat_q;
        abort_flag_d = abort_flag_q;
        words_done_d = words_done_q;

        case (state_q)
            S_IDLE: begin
                // abort is deliberately not looked at while idle
                if (cmd_valid) begin
                    src_d        = cmd_src;
                    dst_d        = cmd_dst;
                    rem_d        = cmd_len;
                    mode_d       = cmd_mode;
                    fill_d       = cmd_fill;
                    words_done_d = '0;
                    abort_flag_d = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = S_FIN;
                    end else if (cmd_mode) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end

            S_RD: begin
                // The read strobe has already been issued this cycle; an
                // abort here drops the word before its write.
                if (abort) begin
                    abort_flag_d = 1'b1;
                    state_d      = S_FIN;
                end else begin
                    lat_d   = LAT_LAST;
                    state_d = S_WT;
                end
            end

            S_WT: begin
                if (abort) begin
                    abort_flag_d = 1'b1;
                    state_d      = S_FIN;
                end else if (lat_q == 3'd0) begin
                    data_d  = readdata;
                    state_d = S_WR;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end

            S_WR: begin
                // The write on the bus this cycle always completes and counts,
                // even when abort arrives with it.
                src_d        = src_q + PTR_ONE;
                dst_d        = dst_q + PTR_ONE;
                rem_d        = rem_q - LEN_ONE;
                words_done_d = words_done_q + LEN_ONE;
                if (abort) begin
                    abort_flag_d = 1'b1;
                    state_d      = S_FIN;
                end else if (rem_q == LEN_ONE) begin
                    state_d = S_FIN;
                end else if (mode_q) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_RD;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register inputs, derived from the state being entered
    // ------------------------------------------------------------------
    always_comb begin
        cs_d      = (state_d == S_RD) || (state_d == S_WR);
        wr_d      = (state_d == S_WR);
        be_d      = cs_d ? '1 : '0;
        ready_d   = (state_d == S_IDLE);
        busy_d    = (state_d != S_IDLE);
        // done lags FIN by one cycle so the pulse sits in the first idle cycle
        done_d    = (state_q == S_FIN);
        aborted_d = (state_q == S_FIN) && abort_flag_q;

        address_d = address_q;
        if (state_d == S_RD) begin
            address_d = src_d;
        end else if (state_d == S_WR) begin
            address_d = dst_d;
        end

        wdata_d = wdata_q;
        if (state_d == S_WR) begin
            wdata_d = mode_d ? fill_d : data_d;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            mode_q       <= 1'b0;
            fill_q       <= '0;
            data_q       <= '0;
            lat_q        <= '0;
            abort_flag_q <= 1'b0;
            words_done_q <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            address_q    <= '0;
            be_q         <= '0;
            cs_q         <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            rem_q        <= rem_d;
            mode_q       <= mode_d;
            fill_q       <= fill_d;
            data_q       <= data_d;
            lat_q        <= lat_d;
            abort_flag_q <= abort_flag_d;
            words_done_q <= words_done_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            address_q    <= address_d;
            be_q         <= be_d;
            cs_q         <= cs_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign words_done = words_done_q;
    assign address    = address_q;
    assign byteenable = be_q;
    assign chipselect = cs_q;
    assign write      = wr_q;
    assign writedata  = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_onchip_mem_block_mover.sv
// ============================================================================
// Module      : tb_onchip_mem_block_mover
// Description : Self-checking bench for onchip_mem_block_mover. Stimulus
//               pushes expected reads, writes, completions, idle snapshots
//               and final RAM contents into queues; a negedge monitor pops
//               and compares them whenever the DUT shows activity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onchip_mem_block_mover;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [9:0]  cmd_src;
    logic [9:0]  cmd_dst;
    logic [10:0] cmd_len;
    logic [31:0] cmd_fill;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [10:0] words_done;
    logic [9:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    onchip_mem_block_mover #(
        .ADDR_W(10), .DATA_W(32), .READ_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .cmd_fill(cmd_fill), .abort(abort), .busy(busy), .done(done),
        .aborted(aborted), .words_done(words_done),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .write(write), .writedata(writedata), .readdata(readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: one-cycle registered read, preloaded with addr + 0x100
    logic [31:0] tb_mem [1024];
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'(i) + 32'h100;
        end else if (chipselect === 1'b1 && write === 1'b1) begin
            tb_mem[address] <= writedata;
        end else if (chipselect === 1'b1) begin
            readdata <= tb_mem[address];
        end
    end

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          cyc;
        bit          opt;
        int          id;
    } acc_t;

    typedef struct {
        bit ab;
        int wmin;
        int wmax;
        int cmin;
        int cmax;
        int id;
    } cmp_t;

    acc_t wq[$];
    acc_t rq[$];
    acc_t mq[$];
    cmp_t cq[$];
    int   iq[$];
    logic [31:0] exp_mem [1024];
    bit   end_req = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // Comparison helpers (used only by the monitor)
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, req);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d..%0d", nm, cyc, act, lo, hi);
        end
    endtask

    task automatic bad(input string nm, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d: got 0x%0h, expected nothing", nm, cyc, act);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        acc_t e;
        cmp_t c;
        int   pending;
        if (chipselect === 1'b1) begin
            chk("byteenable", 64'(byteenable), 64'hF);
            if (write === 1'b1) begin
                if (wq.size() == 0) begin
                    bad("unexpected_write", 64'(address));
                end else begin
                    e = wq.pop_front();
                    chk("write_addr", 64'(address), 64'(e.addr));
                    chk("write_data", 64'(writedata), 64'(e.data));
                    if (e.cyc >= 0) chk("write_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                if (rq.size() == 0) begin
                    bad("unexpected_read", 64'(address));
                end else begin
                    e = rq.pop_front();
                    chk("read_addr", 64'(address), 64'(e.addr));
                    if (e.cyc >= 0) chk("read_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end

        if (done === 1'b1) begin
            if (cq.size() == 0) begin
                bad("unexpected_done", 64'(words_done));
            end else begin
                c = cq.pop_front();
                chk("aborted", 64'(aborted), 64'(c.ab));
                chk_rng("words_done", int'(words_done), c.wmin, c.wmax);
                chk_rng("done_cycle", cyc, c.cmin, c.cmax);
                pending = 0;
                while (wq.size() > 0 && wq[0].id == c.id) begin
                    if (!wq[0].opt) pending++;
                    void'(wq.pop_front());
                end
                while (rq.size() > 0 && rq[0].id == c.id) begin
                    if (!rq[0].opt) pending++;
                    void'(rq.pop_front());
                end
                chk("accesses_missing_at_done", 64'(pending), 64'd0);
            end
        end else if (aborted === 1'b1) begin
            bad("aborted_without_done", 64'(aborted));
        end

        if (iq.size() > 0 && iq[0] == cyc) begin
            void'(iq.pop_front());
            chk("idle_cmd_ready",  64'(cmd_ready),  64'd1);
            chk("idle_busy",       64'(busy),       64'd0);
            chk("idle_done",       64'(done),       64'd0);
            chk("idle_aborted",    64'(aborted),    64'd0);
            chk("idle_words_done", 64'(words_done), 64'd0);
            chk("idle_address",    64'(address),    64'd0);
            chk("idle_byteenable", 64'(byteenable), 64'd0);
            chk("idle_chipselect", 64'(chipselect), 64'd0);
            chk("idle_write",      64'(write),      64'd0);
            chk("idle_writedata",  64'(writedata),  64'd0);
        end

        if (end_req) begin
            chk("pending_writes",      64'(wq.size()), 64'd0);
            chk("pending_reads",       64'(rq.size()), 64'd0);
            chk("pending_completions", 64'(cq.size()), 64'd0);
            chk("pending_idle_checks", 64'(iq.size()), 64'd0);
            foreach (mq[i]) begin
                chk($sformatf("ram_0x%03h", mq[i].addr), 64'(tb_mem[mq[i].addr]), 64'(mq[i].data));
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    // ------------------------------------------------------------------
    // Expectation builders
    // ------------------------------------------------------------------
    task automatic exp_wr(input logic [9:0] a, input logic [31:0] d, input int cy,
                          input bit opt, input int id);
        wq.push_back('{addr: a, data: d, cyc: cy, opt: opt, id: id});
        if (!opt) exp_mem[a] = d;
    endtask

    task automatic exp_rd(input logic [9:0] a, input int cy, input bit opt, input int id);
        rq.push_back('{addr: a, data: 32'd0, cyc: cy, opt: opt, id: id});
    endtask

    task automatic exp_done(input bit ab, input int wmin, input int wmax,
                            input int cmin, input int cmax, input int id);
        cq.push_back('{ab: ab, wmin: wmin, wmax: wmax, cmin: cmin, cmax: cmax, id: id});
    endtask

    // COPY: read at A+1+3k, write at A+3+3k, done at A+3*len+2
    task automatic exp_copy(input logic [9:0] src, input logic [9:0] dst, input int len,
                            input int a, input int id);
        logic [9:0] s;
        logic [9:0] d;
        for (int k = 0; k < len; k++) begin
            s = src + 10'(k);
            d = dst + 10'(k);
            exp_rd(s, a + 1 + 3 * k, 1'b0, id);
            exp_wr(d, exp_mem[s], a + 3 + 3 * k, 1'b0, id);
        end
        exp_done(1'b0, len, len, a + 3 * len + 2, a + 3 * len + 2, id);
    endtask

    task automatic exp_ram(input logic [9:0] a);
        mq.push_back('{addr: a, data: exp_mem[a], cyc: -1, opt: 1'b0, id: 0});
    endtask

    // ------------------------------------------------------------------
    // Stimulus (always called #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready === 1'b1) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input bit mode, input logic [9:0] src, input logic [9:0] dst,
                         input logic [10:0] len, input logic [31:0] fill, output int acc);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
        cmd_fill  = fill;
        acc       = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int a;
        int a2;
        for (int i = 0; i < 1024; i++) exp_mem[i] = 32'(i) + 32'h100;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = '0;
        cmd_fill  = '0;
        abort     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        iq.push_back(cyc);
        @(posedge clk);
        #1;

        // FILL 0x010 x4; abort held high while idle must be ignored
        abort = 1'b1;
        issue(1'b1, 10'h000, 10'h010, 11'd4, 32'hDEADBEEF, a);
        abort = 1'b0;
        for (int k = 0; k < 4; k++) exp_wr(10'h010 + 10'(k), 32'hDEADBEEF, a + 1 + k, 1'b0, 1);
        exp_done(1'b0, 4, 4, a + 6, a + 6, 1);

        // COPY 0x000 -> 0x200 x8
        issue(1'b0, 10'h000, 10'h200, 11'd8, 32'h0, a);
        exp_copy(10'h000, 10'h200, 8, a, 2);

        // COPY with source wrap 0x3FE -> 0x100 x4
        issue(1'b0, 10'h3FE, 10'h100, 11'd4, 32'h0, a);
        exp_copy(10'h3FE, 10'h100, 4, a, 3);

        // COPY 0x040 -> 0x300 x16, abort right after the 5th write
        issue(1'b0, 10'h040, 10'h300, 11'd16, 32'h0, a);
        for (int k = 0; k < 5; k++) begin
            exp_rd(10'h040 + 10'(k), a + 1 + 3 * k, 1'b0, 4);
            exp_wr(10'h300 + 10'(k), exp_mem[10'h040 + 10'(k)], a + 3 + 3 * k, 1'b0, 4);
        end
        exp_rd(10'h045, -1, 1'b1, 4);
        exp_wr(10'h305, 32'h145, -1, 1'b1, 4);
        exp_done(1'b1, 5, 6, a + 16, a + 20, 4);
        repeat (15) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;

        // len = 0, with the next command presented while still busy
        wait_ready();
        cmd_valid = 1'b1;
        cmd_mode  = 1'b1;
        cmd_dst   = 10'h300;
        cmd_len   = 11'd0;
        cmd_fill  = 32'h00000BAD;
        a = cyc;
        @(posedge clk);
        #1;
        cmd_dst  = 10'h080;
        cmd_len  = 11'd2;
        cmd_fill = 32'h12345678;
        exp_done(1'b0, 0, 0, a + 2, a + 2, 5);
        a2 = a + 2;
        exp_wr(10'h080, 32'h12345678, a2 + 1, 1'b0, 6);
        exp_wr(10'h081, 32'h12345678, a2 + 2, 1'b0, 6);
        exp_done(1'b0, 2, 2, a2 + 4, a2 + 4, 6);
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 1'b0;

        // FILL 0x000 x100, reset during the write of word 9
        issue(1'b1, 10'h000, 10'h000, 11'd100, 32'hA5A50000, a);
        for (int k = 0; k < 10; k++) exp_wr(10'(k), 32'hA5A50000, a + 1 + k, 1'b0, 7);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        iq.push_back(cyc);
        repeat (20) @(posedge clk);
        #1;

        exp_ram(10'h009);
        exp_ram(10'h00A);
        exp_ram(10'h00B);
        exp_ram(10'h010);
        exp_ram(10'h013);
        exp_ram(10'h014);
        exp_ram(10'h200);
        exp_ram(10'h207);
        exp_ram(10'h100);
        exp_ram(10'h102);
        exp_ram(10'h103);
        exp_ram(10'h304);
        exp_ram(10'h081);
        end_req = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL monitor did not end the run");
        $fatal(1, "monitor did not end the run");
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
